// File: rtl/dense_vec_serializer.sv
// Double-buffered vector-to-chunk serializer: captures IN_SIZE elements on a strobe
// and streams them as IN_SIZE/CHUNK beats of CHUNK elements with downstream backpressure.
module dense_vec_serializer #(
   parameter int IN_SIZE = 128,
   parameter int CHUNK   = 4,
   parameter int BW      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           vld_in,
   input  logic [IN_SIZE-1:0][BW-1:0]     data_in,
   input  logic                           out_rdy,
   output logic                           vld_out,
   output logic [CHUNK-1:0][BW-1:0]       data_out,
   output logic                           last_out,
   output logic                           busy,
   output logic                           ovf
);

   localparam int NUM_BEATS = IN_SIZE / CHUNK;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_full;
   logic [1:0]            w_full_nxt;
   logic                  r_wr_sel;
   logic                  r_rd_sel;
   logic                  w_wr_sel_nxt;
   logic                  w_rd_sel_nxt;
   logic [BEAT_W-1:0]     r_beat;
   logic [BEAT_W-1:0]     w_beat_nxt;
   logic                  r_ovf;
   logic                  w_xfer;
   logic                  w_last_xfer;
   logic                  w_free;
   logic                  w_cap;
   logic                  w_drop;

   // Each bank is viewed as NUM_BEATS chunks so a beat is a single indexed select.
   logic [NUM_BEATS-1:0][CHUNK*BW-1:0] r_bank [2];

   always_comb begin
      w_xfer       = (r_state == S_STREAM) && out_rdy;
      w_last_xfer  = w_xfer && (r_beat == LAST_BEAT);
      // A bank being drained of its final beat this cycle is already free for capture.
      w_free       = !r_full[r_wr_sel] || (w_last_xfer && (r_rd_sel == r_wr_sel));
      w_cap        = vld_in && w_free;
      w_drop       = vld_in && !w_free;

      w_beat_nxt   = r_beat;
      if (w_last_xfer)
         w_beat_nxt = '0;
      else if (w_xfer)
         w_beat_nxt = r_beat + 1'b1;

      w_full_nxt   = r_full;
      if (w_last_xfer)
         w_full_nxt[r_rd_sel] = 1'b0;
      if (w_cap)
         w_full_nxt[r_wr_sel] = 1'b1;

      w_rd_sel_nxt = r_rd_sel ^ w_last_xfer;
      w_wr_sel_nxt = r_wr_sel ^ w_cap;
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      if (w_full_nxt[w_rd_sel_nxt])
         w_state_nxt = S_STREAM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_full   <= '0;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_beat   <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_full   <= w_full_nxt;
         r_wr_sel <= w_wr_sel_nxt;
         r_rd_sel <= w_rd_sel_nxt;
         r_beat   <= w_beat_nxt;
         r_ovf    <= r_ovf | w_drop;
      end
   end

   always_ff @(posedge clk) begin
      if (w_cap)
         r_bank[r_wr_sel] <= data_in;
   end

   assign vld_out  = (r_state == S_STREAM);
   assign data_out = vld_out ? r_bank[r_rd_sel][r_beat] : '0;
   assign last_out = vld_out && (r_beat == LAST_BEAT);
   assign busy     = |r_full;
   assign ovf      = r_ovf;

endmodule

// File: tb/tb_dense_vec_serializer.sv
// Directed bench for dense_vec_serializer (IN_SIZE=8, CHUNK=2, BW=16):
// a per-cycle vector table plus hand-written stall, capture-on-free and reset sequences.
module tb_dense_vec_serializer;

   localparam int IN_SIZE = 8;
   localparam int CHUNK   = 2;
   localparam int BW      = 16;

   logic                       clk;
   logic                       rst_n;
   logic                       vld_in;
   logic [IN_SIZE-1:0][BW-1:0] data_in;
   logic                       out_rdy;
   logic                       vld_out;
   logic [CHUNK-1:0][BW-1:0]   data_out;
   logic                       last_out;
   logic                       busy;
   logic                       ovf;

   int n_checks = 0;
   int n_err    = 0;

   dense_vec_serializer #(
      .IN_SIZE (IN_SIZE),
      .CHUNK   (CHUNK),
      .BW      (BW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld_in   (vld_in),
      .data_in  (data_in),
      .out_rdy  (out_rdy),
      .vld_out  (vld_out),
      .data_out (data_out),
      .last_out (last_out),
      .busy     (busy),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit vld;
      int base;
      bit rdy;
      bit e_vld;
      int e_d0;
      int e_d1;
      bit e_last;
      bit e_busy;
      bit e_ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit vld, int base, bit rdy, bit ev, int d0, int d1,
                               bit el, bit eb, bit eo);
      vec_t r;
      r.vld = vld; r.base = base; r.rdy = rdy;
      r.e_vld = ev; r.e_d0 = d0; r.e_d1 = d1;
      r.e_last = el; r.e_busy = eb; r.e_ovf = eo;
      return r;
   endfunction

   // Element i of a vector with base b is b+i+1.
   function automatic logic [IN_SIZE-1:0][BW-1:0] mkvec(int base);
      logic [IN_SIZE-1:0][BW-1:0] v;
      for (int i = 0; i < IN_SIZE; i++) v[i] = 16'(base + i + 1);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input bit ev, input int d0, input int d1,
                            input bit el, input bit eb, input bit eo);
      chk($sformatf("%s.vld_out", tag), 32'(vld_out), 32'(ev));
      chk($sformatf("%s.d0", tag), 32'(data_out[0]), 32'(d0));
      chk($sformatf("%s.d1", tag), 32'(data_out[1]), 32'(d1));
      chk($sformatf("%s.last_out", tag), 32'(last_out), 32'(el));
      chk($sformatf("%s.busy", tag), 32'(busy), 32'(eb));
      chk($sformatf("%s.ovf", tag), 32'(ovf), 32'(eo));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      vld_in  = 1'b0;
      out_rdy = 1'b1;
      data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  exp_b;
      bit  done;
      int  last_cnt;
      bit  prev_last;
      int  base;
      int  bt;

      // Single frame A=1..8.
      tbl.push_back(mk(1,   0, 1, 1,   1,   2, 0, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1,   3,   4, 0, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1,   5,   6, 0, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1,   7,   8, 1, 1, 0));
      tbl.push_back(mk(0,   0, 1, 0,   0,   0, 0, 0, 0));
      // Back-to-back: A at cycle 0, B=101..108 at cycle 2, no bubble.
      tbl.push_back(mk(1,   0, 1, 1,   1,   2, 0, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1,   3,   4, 0, 1, 0));
      tbl.push_back(mk(1, 100, 1, 1,   5,   6, 0, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1,   7,   8, 1, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1, 101, 102, 0, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1, 103, 104, 0, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1, 105, 106, 0, 1, 0));
      tbl.push_back(mk(0,   0, 1, 1, 107, 108, 1, 1, 0));
      tbl.push_back(mk(0,   0, 1, 0,   0,   0, 0, 0, 0));
      // Overflow: three captures while stalled; the third (base 200) is dropped.
      tbl.push_back(mk(1,   0, 0, 1,   1,   2, 0, 1, 0));
      tbl.push_back(mk(1, 100, 0, 1,   1,   2, 0, 1, 0));
      tbl.push_back(mk(1, 200, 0, 1,   1,   2, 0, 1, 1));
      tbl.push_back(mk(0,   0, 1, 1,   3,   4, 0, 1, 1));
      tbl.push_back(mk(0,   0, 1, 1,   5,   6, 0, 1, 1));
      tbl.push_back(mk(0,   0, 1, 1,   7,   8, 1, 1, 1));
      tbl.push_back(mk(0,   0, 1, 1, 101, 102, 0, 1, 1));
      tbl.push_back(mk(0,   0, 1, 1, 103, 104, 0, 1, 1));
      tbl.push_back(mk(0,   0, 1, 1, 105, 106, 0, 1, 1));
      tbl.push_back(mk(0,   0, 1, 1, 107, 108, 1, 1, 1));
      tbl.push_back(mk(0,   0, 1, 0,   0,   0, 0, 0, 1));

      do_reset();
      check_out("reset", 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         vld_in  = tbl[i].vld;
         data_in = mkvec(tbl[i].base);
         out_rdy = tbl[i].rdy;
         tick();
         vld_in  = 1'b0;
         check_out($sformatf("tbl%0d", i), tbl[i].e_vld, tbl[i].e_d0, tbl[i].e_d1,
                   tbl[i].e_last, tbl[i].e_busy, tbl[i].e_ovf);
      end

      // Reset mid-frame (ovf is still set from the overflow rows).
      out_rdy = 1'b1;
      vld_in  = 1'b1;
      data_in = mkvec(0);
      tick();
      vld_in  = 1'b0;
      tick();
      tick();
      check_out("rst.beat2", 1, 5, 6, 0, 1, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_out("rst.async", 0, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      check_out("rst.held", 0, 0, 0, 0, 0, 0);
      vld_in  = 1'b1;
      data_in = mkvec(100);
      tick();
      vld_in  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_out($sformatf("rst.b%0d", k), 1, 101 + 2 * k, 102 + 2 * k, k == 3, 1, 0);
         tick();
      end
      check_out("rst.end", 0, 0, 0, 0, 0, 0);

      // Stall: out_rdy follows 1,0,0,1,0,0,...
      do_reset();
      vld_in  = 1'b1;
      data_in = mkvec(0);
      tick();
      vld_in  = 1'b0;
      check_out("stall.c", 1, 1, 2, 0, 1, 0);
      exp_b     = 0;
      done      = 0;
      last_cnt  = 0;
      prev_last = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         out_rdy = (k % 3 == 0);
         tick();
         if (out_rdy) exp_b++;
         if (exp_b == 4) begin
            check_out($sformatf("stall.k%0d", k), 0, 0, 0, 0, 0, 0);
            done = 1;
         end else begin
            check_out($sformatf("stall.k%0d", k), 1, 2 * exp_b + 1, 2 * exp_b + 2,
                      exp_b == 3, 1, 0);
         end
         if (last_out && !prev_last) last_cnt++;
         prev_last = last_out;
      end
      chk("stall.done", 32'(done), 32'd1);
      chk("stall.last_cnt", 32'(last_cnt), 32'd1);

      // Capture into the bank freed by the final beat of the same edge.
      do_reset();
      out_rdy = 1'b1;
      vld_in  = 1'b1;
      data_in = mkvec(0);
      tick();
      check_out("sim.a0", 1, 1, 2, 0, 1, 0);
      data_in = mkvec(100);
      tick();
      vld_in  = 1'b0;
      check_out("sim.a1", 1, 3, 4, 0, 1, 0);
      tick();
      check_out("sim.a2", 1, 5, 6, 0, 1, 0);
      tick();
      check_out("sim.a3", 1, 7, 8, 1, 1, 0);
      vld_in  = 1'b1;
      data_in = mkvec(200);
      tick();
      vld_in  = 1'b0;
      data_in = '0;
      for (int j = 0; j < 8; j++) begin
         base = (j < 4) ? 100 : 200;
         bt   = j % 4;
         check_out($sformatf("sim.s%0d", j), 1, base + 2 * bt + 1, base + 2 * bt + 2,
                   bt == 3, 1, 0);
         tick();
      end
      check_out("sim.end", 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
